axi_lite_cmd_arb: RTL
=====================

# axi_lite_cmd_arb

Round-robin arbiter that shares one `axi_lite_master` command stream between `NUM_REQ` requesters. Each requester presents a stream command: `{addr, data}` on tdata and a 2-bit tkeep, where `2'b11` is a write and `2'b10` is a read. The arbiter grants one requester at a time, passes its command through to the master, and tags the output with the grant index. It sits directly upstream of `axi_lite_master`, between the command sources and the master's tvalid/tdata/tkeep/tready port.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..16)
- `DATA_WD`, 8, data field width
- `ADDR_WD`, 8, address field width
- `KEEP_WD`, `(ADDR_WD+DATA_WD)>>3`, tkeep width per stream
- `BURST_MAX`, 4, maximum consecutive transfers per grant (used only with `AXI_LITE_ARB_BURST_EN`; ≥1)
- `ID_WD`, `$clog2(NUM_REQ)`, grant index width

Ports:
- `clk`  in  1  sole clock; all logic on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `s_tvalid`  in  NUM_REQ  per-requester command valid
- `s_tdata`  in  NUM_REQ*(ADDR_WD+DATA_WD)  requester i at slice i; `{addr, data}`
- `s_tkeep`  in  NUM_REQ*KEEP_WD  requester i at slice i
- `s_tready`  out  NUM_REQ  per-requester ready
- `m_tvalid`  out  1  to master tvalid
- `m_tdata`  out  ADDR_WD+DATA_WD  to master tdata
- `m_tkeep`  out  KEEP_WD  to master tkeep
- `m_tready`  in  1  from master tready
- `m_tid`  out  ID_WD  index of the granted requester

## Operation
- FSM has two states, IDLE and GRANT. Registers: `state`, `gnt` (ID_WD), `last` (ID_WD), `burst_cnt`.
- **IDLE**
  - `m_tvalid` = 0 and all `s_tready` = 0.
  - If any `s_tvalid` is high, search starts at `last+1` and wraps modulo `NUM_REQ`. The first active requester is loaded into `gnt`, and the FSM moves to GRANT.
- **GRANT** (combinational pass-through)
  - `m_tvalid` = `s_tvalid[gnt]`.
  - `m_tdata` and `m_tkeep` come from slice `gnt`.
  - `s_tready[gnt]` = `m_tready`; all other `s_tready` = 0.
  - `m_tid` = `gnt`.
- **Fire** = `m_tvalid && m_tready`.
- **Leaving GRANT**
  - On fire when the burst limit is reached, or when `s_tvalid[gnt]` is 0 while no fire occurs: go to IDLE and set `last` <= `gnt`.
  - Otherwise stay in GRANT and increment `burst_cnt`. `burst_cnt` is cleared on entry to GRANT.
- **tkeep** is forwarded unmodified. Values other than `2'b11`/`2'b10` are not checked.
- **Data stability:** a requester must hold valid and data stable until fire. Because the datapath is a pure mux, stable inputs give stable outputs.

## Timing
- Reset values:
  - state = IDLE
  - `last` = `NUM_REQ-1`, so requester 0 wins first
  - `gnt` = 0, `burst_cnt` = 0
  - `m_tvalid` = 0, `s_tready` = 0, `m_tid` = 0
  - `m_tdata` and `m_tkeep` are don't-care while `m_tvalid` = 0
- Arbitration latency: requester valid seen in IDLE at edge N gives `m_tvalid` high in cycle N+1.
- Zero-latency data path in GRANT.
- Minimum throughput per grant is one transfer per 2 cycles (fire cycle plus the IDLE arbitration cycle).
- Simultaneous requests are resolved by the round-robin order from `last+1`.
- A new request arriving while another requester is granted waits; it is not preempted.
- Reset asserted mid-GRANT aborts the grant next edge. The outstanding beat is not transferred, and the requester must re-present it.
- `m_tready` high while `m_tvalid` is low has no effect.

## Configuration
- Macro `AXI_LITE_ARB_BURST_EN`.
- **Defined:** the grant is held for up to `BURST_MAX` fires. Leave GRANT on the fire with `burst_cnt == BURST_MAX-1`, or when `s_tvalid[gnt]` is low.
- **Undefined:**
  - Leave GRANT on every fire (one transfer per grant).
  - The `BURST_MAX` parameter and the `burst_cnt` register are absent or unused.

## Structure
- Shared package `axi_lite_pkg`:
  - cmd field widths
  - tkeep encodings: `KEEP_WR = 2'b11`, `KEEP_RD = 2'b10`
  - FSM state enum: `ARB_IDLE`, `ARB_GRANT`
- One sub-module, `rr_pick`: combinational round-robin priority picker.
  - Inputs: req vector, `last`.
  - Outputs: `found`, index.
  - Implemented as a double-width rotate-and-priority-encode.

## Test plan
- Single requester 1 with continuous valid, `m_tready` = 1, macro off → one fire every 2 cycles; `m_tid` = 1 on every fire; `m_tdata` matches requester 1's slice.
- All 4 requesters valid after reset, macro off → fire order 0, 1, 2, 3, 0, …; no requester skipped.
- Macro on, `BURST_MAX` = 4, requesters 0 and 2 continuously valid → 4 fires with `m_tid` = 0, then 4 fires with `m_tid` = 2, repeating.
- Requester 3 granted, `m_tready` held 0 for 5 cycles → `m_tvalid`, `m_tdata` and `m_tkeep` stable; `s_tready` = 0 for all requesters; fire occurs when `m_tready` rises.
- `rst` pulsed for 1 cycle while in GRANT → next cycle `m_tvalid` = 0 and `s_tready` = 0; after release requester 0 wins first.
- Read (`tkeep` = `2'b10`) and write (`tkeep` = `2'b11`) commands interleaved across requesters → `m_tkeep` matches the granted slice exactly.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared definitions for the axi_lite command path: field widths, tkeep encodings,
// and the arbiter state enum.
package axi_lite_pkg;

  localparam int ADDR_WD_DEF = 8;
  localparam int DATA_WD_DEF = 8;
  localparam int CMD_WD_DEF  = ADDR_WD_DEF + DATA_WD_DEF;
  localparam int KEEP_WD_DEF = CMD_WD_DEF >> 3;

  localparam logic [1:0] KEEP_WR = 2'b11;
  localparam logic [1:0] KEEP_RD = 2'b10;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after last+1, wrapping.
// Doubles req, rotates it by the start point, then priority-encodes the result.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          found,
  output logic [IW-1:0] idx
);

  localparam logic [IW:0] N_W = (IW+1)'(N);

  logic [IW-1:0] start;
  logic [N-1:0]  rot;
  logic [IW-1:0] off;
  logic [IW:0]   sum;

  always_comb begin
    start = (last == IW'(N-1)) ? '0 : last + 1'b1;
    rot   = N'({req, req} >> start);
    off   = '0;
    // Descending scan so the lowest set bit (closest to start) wins.
    for (int i = N-1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
    sum = {1'b0, start} + {1'b0, off};
    if (sum >= N_W) sum = sum - N_W;
    idx   = sum[IW-1:0];
    found = |req;
  end

endmodule

// File: rtl/axi_lite_cmd_arb.sv
// Round-robin arbiter that funnels NUM_REQ command streams into one axi_lite_master port.
// Define AXI_LITE_ARB_BURST_EN to hold a grant for up to BURST_MAX fires.
module axi_lite_cmd_arb
  import axi_lite_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_WD   = DATA_WD_DEF,
  parameter int ADDR_WD   = ADDR_WD_DEF,
  parameter int KEEP_WD   = (ADDR_WD + DATA_WD) >> 3,
`ifdef AXI_LITE_ARB_BURST_EN
  parameter int BURST_MAX = 4,
`endif
  parameter int ID_WD     = $clog2(NUM_REQ)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   s_tvalid,
  input  logic [NUM_REQ*(ADDR_WD+DATA_WD)-1:0] s_tdata,
  input  logic [NUM_REQ*KEEP_WD-1:0]           s_tkeep,
  output logic [NUM_REQ-1:0]                   s_tready,
  output logic                                 m_tvalid,
  output logic [ADDR_WD+DATA_WD-1:0]           m_tdata,
  output logic [KEEP_WD-1:0]                   m_tkeep,
  input  logic                                 m_tready,
  output logic [ID_WD-1:0]                     m_tid
);

  localparam int CMD_WD = ADDR_WD + DATA_WD;

  logic [NUM_REQ-1:0][CMD_WD-1:0]  cmd_arr;
  logic [NUM_REQ-1:0][KEEP_WD-1:0] keep_arr;
  assign cmd_arr  = s_tdata;
  assign keep_arr = s_tkeep;

  arb_state_e       state, state_d;
  logic [ID_WD-1:0] gnt, gnt_d;
  logic [ID_WD-1:0] last, last_d;
  logic             found;
  logic [ID_WD-1:0] pick;
  logic             fire;
  logic             burst_done;

`ifdef AXI_LITE_ARB_BURST_EN
  localparam int BW = $clog2(BURST_MAX + 1);
  logic [BW-1:0] burst_cnt, burst_cnt_d;
  assign burst_done = (burst_cnt == BW'(BURST_MAX - 1));
`else
  assign burst_done = 1'b1;
`endif

  rr_pick #(.N(NUM_REQ), .IW(ID_WD)) u_pick (
    .req   (s_tvalid),
    .last  (last),
    .found (found),
    .idx   (pick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
      gnt   <= '0;
      last  <= ID_WD'(NUM_REQ - 1);
`ifdef AXI_LITE_ARB_BURST_EN
      burst_cnt <= '0;
`endif
    end else begin
      state <= state_d;
      gnt   <= gnt_d;
      last  <= last_d;
`ifdef AXI_LITE_ARB_BURST_EN
      burst_cnt <= burst_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d  = state;
    gnt_d    = gnt;
    last_d   = last;
    m_tvalid = 1'b0;
    s_tready = '0;
    fire     = 1'b0;
    // Data mux runs unconditionally; contents are only meaningful with m_tvalid.
    m_tdata  = cmd_arr[gnt];
    m_tkeep  = keep_arr[gnt];
    m_tid    = gnt;
`ifdef AXI_LITE_ARB_BURST_EN
    burst_cnt_d = burst_cnt;
`endif
    case (state)
      ARB_IDLE: begin
        if (found) begin
          state_d = ARB_GRANT;
          gnt_d   = pick;
`ifdef AXI_LITE_ARB_BURST_EN
          burst_cnt_d = '0;
`endif
        end
      end
      ARB_GRANT: begin
        m_tvalid      = s_tvalid[gnt];
        s_tready[gnt] = m_tready;
        fire          = m_tvalid && m_tready;
        // A requester that withdraws valid releases the grant without transferring.
        if ((fire && burst_done) || !s_tvalid[gnt]) begin
          state_d = ARB_IDLE;
          last_d  = gnt;
        end
`ifdef AXI_LITE_ARB_BURST_EN
        else if (fire) begin
          burst_cnt_d = burst_cnt + 1'b1;
        end
`endif
      end
      default: state_d = ARB_IDLE;
    endcase
  end

endmodule
